// File: rtl/stopwatch_counter.sv
// stopwatch_counter: prescaled mm:ss.hh BCD stopwatch with lap-freeze display and rollover pulse
module stopwatch_counter #(
  parameter int DIV_COUNT = 100000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        count_enable,
  input  logic        count_clear,
  input  logic        count_lap,
  output logic [23:0] live_bcd,
  output logic [23:0] disp_bcd,
  output logic        lap_active,
  output logic        wrap_pulse
);
  localparam int PW = $clog2(DIV_COUNT);
  typedef enum logic {LIVE, FROZEN} lap_state_t;
  lap_state_t state, state_d;
  logic [PW-1:0] presc, presc_d;
  logic [23:0] snap, snap_d, live_d, inc;
  logic lap_q, tick, carry, rise, fall;
  assign tick = count_enable && presc == PW'(DIV_COUNT - 1);
  assign rise = count_lap && !lap_q;
  assign fall = !count_lap && lap_q;
  // digit 0 is hundredths; sec_tens (3) and min_tens (5) roll over at 5, the rest at 9
  always_comb begin
    inc = live_bcd;
    carry = 1'b1;
    for (int i = 0; i < 6; i++) begin
      inc[4*i +: 4] = !carry ? live_bcd[4*i +: 4] :
                      live_bcd[4*i +: 4] == ((i == 3 || i == 5) ? 4'd5 : 4'd9) ? 4'd0 : live_bcd[4*i +: 4] + 4'd1;
      carry = carry && live_bcd[4*i +: 4] == ((i == 3 || i == 5) ? 4'd5 : 4'd9);
    end
  end
  always_comb begin
    state_d = count_clear ? LIVE :
              (state == LIVE && rise) ? FROZEN :
              (state == FROZEN && fall) ? LIVE : state;
    presc_d = (count_clear || tick) ? '0 : count_enable ? presc + 1'b1 : presc;
    live_d  = count_clear ? '0 : tick ? inc : live_bcd;
    snap_d  = count_clear ? '0 : (state == LIVE && rise) ? live_bcd : snap;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= LIVE;
      presc      <= '0;
      live_bcd   <= '0;
      snap       <= '0;
      disp_bcd   <= '0;
      lap_q      <= 1'b0;
      lap_active <= 1'b0;
      wrap_pulse <= 1'b0;
    end else begin
      state      <= state_d;
      presc      <= presc_d;
      live_bcd   <= live_d;
      snap       <= snap_d;
      disp_bcd   <= state_d == FROZEN ? snap_d : live_d;
      lap_q      <= count_lap;
      lap_active <= state_d == FROZEN;
      wrap_pulse <= !count_clear && tick && carry;
    end
  end
endmodule

// File: tb/tb_stopwatch_counter.sv
// tb_stopwatch_counter: randomized and directed checks against a centisecond-count reference model
module tb_stopwatch_counter;
  localparam int DIV = 4;
  localparam int FULL = 360000;
  logic clk = 1'b0, rst_n = 1'b0, en = 1'b0, clr = 1'b0, lap = 1'b0;
  logic [23:0] live_bcd, disp_bcd;
  logic lap_active, wrap_pulse;
  int tests = 0, fails = 0;
  int m_cs, m_pre, m_snap;
  bit m_frozen, m_prev, m_wrap;

  stopwatch_counter #(.DIV_COUNT(DIV)) dut (
    .clk(clk), .rst_n(rst_n), .count_enable(en), .count_clear(clr), .count_lap(lap),
    .live_bcd(live_bcd), .disp_bcd(disp_bcd), .lap_active(lap_active), .wrap_pulse(wrap_pulse)
  );

  always #5 clk = ~clk;

  function automatic logic [23:0] bcd(int v);
    int m, s, h;
    m = v / 6000;
    s = (v / 100) % 60;
    h = v % 100;
    return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10), 4'(h / 10), 4'(h % 10)};
  endfunction

  function automatic logic [23:0] exp_disp();
    return m_frozen ? bcd(m_snap) : bcd(m_cs);
  endfunction

  // reference behaviour for one rising edge, using the inputs present at that edge
  function automatic void step();
    if (!rst_n) begin
      m_cs = 0; m_pre = 0; m_snap = 0; m_frozen = 0; m_prev = 0; m_wrap = 0;
    end else if (clr) begin
      m_cs = 0; m_pre = 0; m_snap = 0; m_frozen = 0; m_wrap = 0; m_prev = lap;
    end else begin
      m_wrap = 0;
      if (!m_frozen && lap && !m_prev) begin
        m_frozen = 1;
        m_snap = m_cs;
      end else if (m_frozen && !lap && m_prev) m_frozen = 0;
      if (en) begin
        if (m_pre == DIV - 1) begin
          m_pre = 0;
          m_cs = (m_cs + 1) % FULL;
          m_wrap = m_cs == 0;
        end else m_pre++;
      end
      m_prev = lap;
    end
  endfunction

  task automatic cyc(int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      step();
      @(negedge clk);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0; en = 1'b0; clr = 1'b0; lap = 1'b0;
    cyc(2);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b1; en = 1'b1; lap = 1'b0;
    cyc(7);
    lap = 1'b1;
    cyc(1);
    rst_n = 1'b0; en = $urandom_range(0, 1); lap = $urandom_range(0, 1);
    cyc(1);
    tests++;
    if (live_bcd !== 24'h0 || disp_bcd !== 24'h0 || lap_active !== 1'b0 || wrap_pulse !== 1'b0) begin
      fails++;
      $display("FAIL reset: live=%h disp=%h lap=%b wrap=%b expected all 0", live_bcd, disp_bcd, lap_active, wrap_pulse);
    end
    rst_n = 1'b1; lap = 1'b0; en = 1'b0;
  endtask

  task automatic test_count();
    int wraps = 0;
    do_reset();
    en = 1'b1;
    for (int k = 0; k < 40; k++) begin
      cyc(1);
      wraps += wrap_pulse;
    end
    tests++;
    if (live_bcd !== 24'h000010) begin
      fails++;
      $display("FAIL count40_live: got %h expected 000010", live_bcd);
    end
    tests++;
    if (disp_bcd !== 24'h000010) begin
      fails++;
      $display("FAIL count40_disp: got %h expected 000010", disp_bcd);
    end
    tests++;
    if (wraps != 0) begin
      fails++;
      $display("FAIL count40_wrap: got %0d pulses expected 0", wraps);
    end
  endtask

  task automatic test_minute_carry();
    do_reset();
    en = 1'b1;
    cyc(5999 * DIV);
    tests++;
    if (live_bcd !== 24'h005999) begin
      fails++;
      $display("FAIL preload_5999: got %h expected 005999", live_bcd);
    end
    cyc(DIV);
    tests++;
    if (live_bcd !== 24'h010000) begin
      fails++;
      $display("FAIL minute_carry: got %h expected 010000", live_bcd);
    end
    for (int i = 0; i < 6; i++) begin
      tests++;
      if (live_bcd[4*i +: 4] > ((i == 3 || i == 5) ? 4'd5 : 4'd9)) begin
        fails++;
        $display("FAIL digit_range[%0d]: got %h", i, live_bcd[4*i +: 4]);
      end
    end
  endtask

  task automatic test_wrap();
    int pulses = 0;
    en = 1'b0;
    force dut.live_bcd = 24'h595990;
    @(posedge clk);
    step();
    m_cs = 359990;
    #1 release dut.live_bcd;
    @(negedge clk);
    tests++;
    if (live_bcd !== bcd(m_cs)) begin
      fails++;
      $display("FAIL wrap_preload: got %h expected %h", live_bcd, bcd(m_cs));
    end
    en = 1'b1;
    for (int k = 0; k < 60; k++) begin
      cyc(1);
      pulses += wrap_pulse;
      tests++;
      if (wrap_pulse !== m_wrap || live_bcd !== bcd(m_cs)) begin
        fails++;
        $display("FAIL wrap_cycle%0d: wrap=%b live=%h expected wrap=%b live=%h", k, wrap_pulse, live_bcd, m_wrap, bcd(m_cs));
      end
      if (m_wrap) begin
        tests++;
        if (live_bcd !== 24'h000000) begin
          fails++;
          $display("FAIL wrap_zero: got %h expected 000000", live_bcd);
        end
      end
    end
    tests++;
    if (pulses != 1) begin
      fails++;
      $display("FAIL wrap_pulse_count: got %0d expected 1", pulses);
    end
  endtask

  task automatic test_lap();
    do_reset();
    en = 1'b1;
    cyc(20);
    lap = 1'b1;
    cyc(20);
    tests++;
    if (disp_bcd !== 24'h000005 || lap_active !== 1'b1 || live_bcd !== 24'h000010) begin
      fails++;
      $display("FAIL lap_frozen: disp=%h lap=%b live=%h expected 000005 1 000010", disp_bcd, lap_active, live_bcd);
    end
    lap = 1'b0;
    cyc(1);
    tests++;
    if (disp_bcd !== live_bcd || lap_active !== 1'b0 || disp_bcd !== bcd(m_cs)) begin
      fails++;
      $display("FAIL lap_release: disp=%h live=%h lap=%b expected %h 0", disp_bcd, live_bcd, lap_active, bcd(m_cs));
    end
  endtask

  task automatic test_clear();
    do_reset();
    en = 1'b1;
    cyc(13);
    lap = 1'b1;
    cyc(9);
    clr = 1'b1;
    cyc(1);
    clr = 1'b0; en = 1'b0;
    tests++;
    if (live_bcd !== 24'h0 || disp_bcd !== 24'h0 || lap_active !== 1'b0 || wrap_pulse !== 1'b0) begin
      fails++;
      $display("FAIL clear: live=%h disp=%h lap=%b wrap=%b expected all 0", live_bcd, disp_bcd, lap_active, wrap_pulse);
    end
    cyc(5);
    en = 1'b1;
    cyc(DIV - 1);
    tests++;
    if (live_bcd !== 24'h0) begin
      fails++;
      $display("FAIL clear_presc_early: got %h expected 000000", live_bcd);
    end
    cyc(1);
    tests++;
    if (live_bcd !== 24'h000001) begin
      fails++;
      $display("FAIL clear_presc_tick: got %h expected 000001", live_bcd);
    end
  endtask

  task automatic test_pause();
    do_reset();
    en = 1'b1;
    cyc(2);
    en = 1'b0;
    cyc(10);
    en = 1'b1;
    cyc(1);
    tests++;
    if (live_bcd !== 24'h0) begin
      fails++;
      $display("FAIL pause_early: got %h expected 000000", live_bcd);
    end
    cyc(1);
    tests++;
    if (live_bcd !== 24'h000001) begin
      fails++;
      $display("FAIL pause_tick: got %h expected 000001", live_bcd);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int k = 0; k < 4000; k++) begin
      en = $urandom_range(0, 9) != 0;
      clr = $urandom_range(0, 199) == 0;
      if ($urandom_range(0, 14) == 0) lap = ~lap;
      rst_n = $urandom_range(0, 499) != 0;
      cyc(1);
      tests++;
      if (live_bcd !== bcd(m_cs) || disp_bcd !== exp_disp() || lap_active !== m_frozen || wrap_pulse !== m_wrap) begin
        fails++;
        $display("FAIL random%0d: live=%h disp=%h lap=%b wrap=%b expected %h %h %b %b",
                 k, live_bcd, disp_bcd, lap_active, wrap_pulse, bcd(m_cs), exp_disp(), m_frozen, m_wrap);
      end
    end
    rst_n = 1'b1; clr = 1'b0;
  endtask

  initial begin
    cyc(1);
    test_reset();
    test_count();
    test_minute_carry();
    test_wrap();
    test_lap();
    test_clear();
    test_pause();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
